// File: rtl/bcd_to_bin_seq_pkg.sv
// ----------------------------------------------------------------------------
// bcd_to_bin_seq_pkg
//   Shared definitions for the sequential BCD-to-binary converter:
//   default sizing, FSM state encoding, BCD digit limit and a digit check
//   helper used on the load path.
// ----------------------------------------------------------------------------
package bcd_to_bin_seq_pkg;

    localparam int unsigned DEF_N_DIGITS = 3;
    localparam int unsigned DEF_BIN_W    = 10;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic digit_bad(input logic [3:0] d);
        return (d > BCD_MAX_DIGIT);
    endfunction

endpackage : bcd_to_bin_seq_pkg

// File: rtl/bcd_to_bin_seq_if.sv
// ----------------------------------------------------------------------------
// bcd_to_bin_seq_if
//   Start/done handshake bundle for bcd_to_bin_seq.
//     start    requester -> converter  request a conversion (seen only in IDLE)
//     bcd_in   requester -> converter  packed BCD, digit 0 in bits [3:0]
//     busy     converter -> requester  converter not idle
//     done     converter -> requester  one-cycle pulse, bin_out/err valid
//     bin_out  converter -> requester  binary result, held until next done
//     err      converter -> requester  an input digit was > 9
// ----------------------------------------------------------------------------
interface bcd_to_bin_seq_if #(
    parameter int unsigned N_DIGITS = bcd_to_bin_seq_pkg::DEF_N_DIGITS,
    parameter int unsigned BIN_W    = bcd_to_bin_seq_pkg::DEF_BIN_W
);
    logic                    start;
    logic [4*N_DIGITS-1:0]   bcd_in;
    logic                    busy;
    logic                    done;
    logic [BIN_W-1:0]        bin_out;
    logic                    err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );

endinterface : bcd_to_bin_seq_if

// File: rtl/bcd_to_bin_seq_digit_adjust.sv
// ----------------------------------------------------------------------------
// bcd_digit_adjust
//   Reverse double-dabble correction for one BCD nibble after a right shift:
//   a nibble of 8 or more has 3 subtracted.
//     din   4-bit nibble after shift
//     dout  corrected nibble
// ----------------------------------------------------------------------------
module bcd_digit_adjust (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Only applied when din >= 8, so the 4-bit subtract cannot underflow.
    always_comb begin
        dout = din;
        if (din >= 4'd8) begin
            dout = din - 4'd3;
        end
    end

endmodule : bcd_digit_adjust

// File: rtl/bcd_to_bin_seq.sv
// ----------------------------------------------------------------------------
// bcd_to_bin_seq
//   Sequential BCD-to-binary converter (reverse double-dabble). A start seen
//   in IDLE latches bcd_in; after BIN_W shift cycles the binary value appears
//   on bin_out with a one-cycle done pulse. Invalid digits (> 9) take a fast
//   path straight to DONE with err set and bin_out cleared.
//     CLOCK_50  clock, all state updates on the rising edge
//     RESET     synchronous active-high reset; aborts any conversion
//     bus       start/bcd_in in, busy/done/bin_out/err out (slave side)
// ----------------------------------------------------------------------------
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int unsigned N_DIGITS = DEF_N_DIGITS,
    parameter int unsigned BIN_W    = DEF_BIN_W
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    bcd_to_bin_seq_if.slave      bus
);

    localparam int unsigned BCD_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_r, bcd_nxt;
    logic [BIN_W-1:0]   bin_r, bin_nxt;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt;
    logic [BIN_W-1:0]   bin_out_r, bin_out_nxt;
    logic               err_r, err_nxt;
    logic               done_r, done_nxt;

    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BIN_W-1:0]   bin_shift;
    logic               in_bad;

    // One shift step: bcd LSB moves into the binary MSB.
    assign bcd_shift = {1'b0, bcd_r[BCD_W-1:1]};
    assign bin_shift = {bcd_r[0], bin_r[BIN_W-1:1]};

    genvar g;
    generate
        for (g = 0; g < N_DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .din  (bcd_shift[4*g +: 4]),
                .dout (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    always_comb begin
        in_bad = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (digit_bad(bus.bcd_in[4*i +: 4])) begin
                in_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= ST_IDLE;
            bcd_r     <= '0;
            bin_r     <= '0;
            cnt_r     <= '0;
            bin_out_r <= '0;
            err_r     <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            bcd_r     <= bcd_nxt;
            bin_r     <= bin_nxt;
            cnt_r     <= cnt_nxt;
            bin_out_r <= bin_out_nxt;
            err_r     <= err_nxt;
            done_r    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bcd_nxt     = bcd_r;
        bin_nxt     = bin_r;
        cnt_nxt     = cnt_r;
        bin_out_nxt = bin_out_r;
        err_nxt     = err_r;
        done_nxt    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    bcd_nxt = bus.bcd_in;
                    bin_nxt = '0;
                    cnt_nxt = '0;
                    if (in_bad) begin
                        bin_out_nxt = '0;
                        err_nxt     = 1'b1;
                        done_nxt    = 1'b1;
                        state_nxt   = ST_DONE;
                    end else begin
                        state_nxt   = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                bcd_nxt = bcd_adj;
                bin_nxt = bin_shift;
                cnt_nxt = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(BIN_W - 1)) begin
                    bin_out_nxt = bin_shift;
                    err_nxt     = 1'b0;
                    done_nxt    = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = done_r;
    assign bus.bin_out = bin_out_r;
    assign bus.err     = err_r;

endmodule : bcd_to_bin_seq

// File: tb/tb_bcd_to_bin_seq.sv
// ----------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//   Self-checking bench for bcd_to_bin_seq (N_DIGITS=3, BIN_W=10).
// ----------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    bcd_to_bin_seq_if #(.N_DIGITS(3), .BIN_W(10)) bus ();

    bcd_to_bin_seq #(.N_DIGITS(3), .BIN_W(10)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus.slave)
    );

    typedef struct {
        logic [11:0] bcd;
        int          exp_bin;
        int          exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done after the start edge has been taken; returns the number
    // of edges after the start edge and how many samples showed busy.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
        if (bus.busy) busy_cnt++;
    endtask

    task automatic run_conv(input string name, input logic [11:0] bcd,
                            input int exp_bin, input int exp_err);
        int lat, bc;
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        tick();
        bus.start  = 1'b0;
        wait_done(lat, bc);
        check({name, " latency"}, lat, exp_err ? 0 : 10);
        check({name, " bin_out"}, int'(bus.bin_out), exp_bin);
        check({name, " err"}, int'(bus.err), exp_err);
        tick();
        if (!bus.busy) bc = bc;
        else bc++;
        check({name, " busy cycles"}, bc, exp_err ? 1 : 11);
        check({name, " done pulse width"}, int'(bus.done), 0);
        tick();
        check({name, " idle after"}, int'(bus.busy), 0);
        check({name, " bin_out held"}, int'(bus.bin_out), exp_bin);
    endtask

    initial begin
        vec_t vecs[$];
        int lat, bc, dones;

        vecs.push_back('{12'h000,   0, 0});
        vecs.push_back('{12'h255, 255, 0});
        vecs.push_back('{12'h999, 999, 0});
        vecs.push_back('{12'h100, 100, 0});
        vecs.push_back('{12'h009,   9, 0});
        vecs.push_back('{12'h1A5,   0, 1});
        vecs.push_back('{12'h042,  42, 0});
        vecs.push_back('{12'h00A,   0, 1});
        vecs.push_back('{12'h090,  90, 0});
        vecs.push_back('{12'hF00,   0, 1});
        vecs.push_back('{12'h512, 512, 0});

        bus.start  = 1'b0;
        bus.bcd_in = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset bin_out", int'(bus.bin_out), 0);
        check("reset err", int'(bus.err), 0);

        foreach (vecs[i]) begin
            run_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err);
        end

        // start pulsed again while converting: ignored, bcd_in change ignored
        bus.start  = 1'b1;
        bus.bcd_in = 12'h123;
        tick();
        bus.start  = 1'b0;
        tick(); tick(); tick();
        bus.start  = 1'b1;
        bus.bcd_in = 12'h777;
        tick();
        bus.start  = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        check("busy start latency", lat + 4, 10);
        check("busy start bin_out", int'(bus.bin_out), 123);
        // back-to-back: start presented for the earliest legal edge
        tick();
        bus.bcd_in = 12'h456;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        wait_done(lat, bc);
        check("b2b latency", lat, 10);
        check("b2b bin_out", int'(bus.bin_out), 456);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("no extra done", dones, 0);

        // reset in the middle of a conversion
        bus.start  = 1'b1;
        bus.bcd_in = 12'h321;
        tick();
        bus.start  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset busy", int'(bus.busy), 0);
        check("midreset done", int'(bus.done), 0);
        check("midreset bin_out", int'(bus.bin_out), 0);
        check("midreset err", int'(bus.err), 0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        check("midreset no done", dones, 0);
        run_conv("after reset", 12'h321, 321, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bcd_to_bin_seq
